// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 8;
    localparam int WORD_SHIFT = 3;
    localparam int CNT_W      = 32;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with a registered read port.
module dmem_array #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // A write leaves the read register untouched, so the last load result is held.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Serialised data-memory responder: one request in flight, fixed LATENCY to response.
// Optional build macro DMEM_STATS_EN adds saturating load/store/error counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [63:0]      req_addr,
    input  logic [63:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_rdata,
    output logic             resp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [CNT_W-1:0] ld_count,
    output logic [CNT_W-1:0] st_count,
    output logic [CNT_W-1:0] err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LATENCY + 1);

    state_t         state;
    logic [LW-1:0]  cnt;
    logic           resp_zero;

    logic           req_wr_p0;
    logic [63:0]    req_addr_p0;
    logic [63:0]    req_wdata_p0;

    logic           acc_go;
    logic           acc_wr;
    logic [63:0]    acc_addr;
    logic [63:0]    acc_wdata;
    logic           acc_err;
    logic [AW-1:0]  acc_idx;
    logic           ram_en;
    logic [63:0]    ram_rdata;

`ifdef DMEM_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    // Access fields come straight from the request port when LATENCY==1,
    // because the RAM access then happens on the acceptance edge itself.
    always_comb begin
        acc_go    = 1'b0;
        acc_wr    = req_wr_p0;
        acc_addr  = req_addr_p0;
        acc_wdata = req_wdata_p0;
        case (state)
            IDLE: begin
                acc_wr    = req_wr;
                acc_addr  = req_addr;
                acc_wdata = req_wdata;
                acc_go    = req_valid && (LATENCY == 1);
            end
            WAIT:    acc_go = (cnt == LW'(1));
            default: acc_go = 1'b0;
        endcase
    end

    assign acc_err = (|acc_addr[WORD_SHIFT-1:0]) || (|(acc_addr >> (AW + WORD_SHIFT)));
    assign acc_idx = acc_addr[AW+WORD_SHIFT-1:WORD_SHIFT];
    // Gating with rst keeps an abandoned store from committing on a reset edge.
    assign ram_en  = acc_go && rst && !acc_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .DATA_W(64),
        .AW    (AW)
    ) u_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (acc_wr),
        .addr (acc_idx),
        .wdata(acc_wdata),
        .rdata(ram_rdata)
    );

    assign resp_rdata = resp_zero ? 64'd0 : ram_rdata;

    // Request capture stage
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            req_wr_p0    <= req_wr;
            req_addr_p0  <= req_addr;
            req_wdata_p0 <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_zero  <= 1'b1;
            resp_err   <= 1'b0;
            cnt        <= '0;
`ifdef DMEM_STATS_EN
            ld_count   <= '0;
            st_count   <= '0;
            err_count  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        state     <= WAIT;
                        cnt       <= LW'(LATENCY - 1);
                    end
                end
                WAIT: cnt <= cnt - 1'b1;
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Response stage entry overrides the WAIT bookkeeping above
            if (acc_go) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                req_ready  <= 1'b0;
                resp_err   <= acc_err;
                resp_zero  <= acc_wr || acc_err;
`ifdef DMEM_STATS_EN
                if (acc_err) begin
                    err_count <= sat_inc(err_count);
                end else if (acc_wr) begin
                    st_count  <= sat_inc(st_count);
                end else begin
                    ld_count  <= sat_inc(ld_count);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1), a per-instance behavioural model.
module tb_dmem_responder;

    localparam int DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rv  [2];
    logic        rw  [2];
    logic        rr  [2];
    logic [63:0] ra  [2];
    logic [63:0] rd  [2];
    logic        rdy [2];
    logic        vld [2];
    logic        err [2];
    logic [63:0] dat [2];
`ifdef DMEM_STATS_EN
    logic [31:0] ldc [2];
    logic [31:0] stc [2];
    logic [31:0] erc [2];
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit addr_bad(input logic [63:0] a);
        return ((a % 64'd8) != 64'd0) || (a >= 64'(DEPTH * 8));
    endfunction

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_ready(rdy[0]), .req_wr(rw[0]), .req_addr(ra[0]), .req_wdata(rd[0]),
        .resp_valid(vld[0]), .resp_ready(rr[0]), .resp_rdata(dat[0]), .resp_err(err[0])
`ifdef DMEM_STATS_EN
        , .ld_count(ldc[0]), .st_count(stc[0]), .err_count(erc[0])
`endif
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(rv[1]), .req_ready(rdy[1]), .req_wr(rw[1]), .req_addr(ra[1]), .req_wdata(rd[1]),
        .resp_valid(vld[1]), .resp_ready(rr[1]), .resp_rdata(dat[1]), .resp_err(err[1])
`ifdef DMEM_STATS_EN
        , .ld_count(ldc[1]), .st_count(stc[1]), .err_count(erc[1])
`endif
    );

    // Model: a request is outstanding from acceptance until consumed; its result
    // becomes visible LAT edges after acceptance, unless a reset intervenes.
    for (genvar k = 0; k < 2; k++) begin : g_model
        localparam int LAT = (k == 0) ? 2 : 1;
        logic [63:0] mem   [DEPTH];
        bit          known [DEPTH];
        bit          pending = 1'b0;
        int          left    = 0;
        bit          m_wr;
        logic [63:0] m_addr;
        logic [63:0] m_wdata;
        logic [63:0] e_rdata = 64'd0;
        bit          e_err   = 1'b0;
        bit          e_known = 1'b1;
        int          e_ld = 0, e_st = 0, e_er = 0;

        always @(negedge clk) begin
            bit fire;
            int idx;
            if (cyc > 0) begin
                chk($sformatf("req_ready[%0d]", k), rdy[k], !pending);
                chk($sformatf("resp_valid[%0d]", k), vld[k], pending && (left == 0));
                chk($sformatf("resp_err[%0d]", k), err[k], e_err);
                if (e_known) chk($sformatf("resp_rdata[%0d]", k), dat[k], e_rdata);
`ifdef DMEM_STATS_EN
                chk($sformatf("ld_count[%0d]", k), ldc[k], 64'(e_ld));
                chk($sformatf("st_count[%0d]", k), stc[k], 64'(e_st));
                chk($sformatf("err_count[%0d]", k), erc[k], 64'(e_er));
`endif
            end
            fire = 1'b0;
            if (!rst) begin
                pending = 1'b0; left = 0;
                e_rdata = 64'd0; e_err = 1'b0; e_known = 1'b1;
                e_ld = 0; e_st = 0; e_er = 0;
            end else if (!pending) begin
                if (rv[k]) begin
                    pending = 1'b1;
                    m_wr = rw[k]; m_addr = ra[k]; m_wdata = rd[k];
                    left = LAT - 1;
                    fire = (left == 0);
                end
            end else if (left > 0) begin
                left--;
                fire = (left == 0);
            end else if (rr[k]) begin
                pending = 1'b0;
            end
            if (fire) begin
                if (addr_bad(m_addr)) begin
                    e_err = 1'b1; e_rdata = 64'd0; e_known = 1'b1; e_er++;
                end else begin
                    idx = int'(m_addr / 64'd8);
                    e_err = 1'b0;
                    if (m_wr) begin
                        mem[idx] = m_wdata; known[idx] = 1'b1;
                        e_rdata = 64'd0; e_known = 1'b1; e_st++;
                    end else begin
                        e_rdata = mem[idx]; e_known = known[idx]; e_ld++;
                    end
                end
            end
        end
    end

    // Tasks start and end at posedge+#1.
    task automatic send(input int k, input logic wr, input logic [63:0] a,
                        input logic [63:0] d, output int t_acc);
        bit took;
        bit done;
        done  = 1'b0;
        t_acc = -1;
        rv[k] = 1'b1; rw[k] = wr; ra[k] = a; rd[k] = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            took = rdy[k];
            @(posedge clk);
            #1;
            if (took) begin
                done  = 1'b1;
                t_acc = cyc - 1;
            end
        end
        rv[k] = 1'b0;
        if (!done) chk($sformatf("accept_timeout[%0d]", k), 64'd0, 64'd1);
    endtask

    task automatic get_resp(input int k, input int stall, output logic [63:0] data,
                            output logic e, output int t_v);
        int  seen;
        bit  done;
        bit  raise;
        seen = 0; done = 1'b0; t_v = -1; data = 64'd0; e = 1'b0;
        rr[k] = (stall == 0);
        for (int i = 0; i < 40 && !done; i++) begin
            raise = 1'b0;
            @(negedge clk);
            if (vld[k]) begin
                if (t_v < 0) begin
                    t_v = cyc; data = dat[k]; e = err[k];
                end else begin
                    chk($sformatf("hold_rdata[%0d]", k), dat[k], data);
                    chk($sformatf("hold_req_ready[%0d]", k), rdy[k], 64'd0);
                end
                if (rr[k]) done = 1'b1;
                else begin
                    seen++;
                    raise = (seen >= stall);
                end
            end
            @(posedge clk);
            #1;
            if (raise) rr[k] = 1'b1;
        end
        rr[k] = 1'b1;
        if (!done) chk($sformatf("resp_timeout[%0d]", k), 64'd0, 64'd1);
    endtask

    task automatic txn(input int k, input logic wr, input logic [63:0] a, input logic [63:0] dw,
                       input int stall, output logic [63:0] dr, output logic e, output int lat);
        int t, tv;
        send(k, wr, a, dw, t);
        get_resp(k, stall, dr, e, tv);
        lat = tv - t;
    endtask

    initial begin
        int          t1, t2, lat;
        logic [63:0] d;
        logic        e;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b0; rw[k] = 1'b0; ra[k] = 64'd0; rd[k] = 64'd0; rr[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_req_ready", rdy[k], 64'd1);
            chk("reset_resp_valid", vld[k], 64'd0);
            chk("reset_resp_rdata", dat[k], 64'd0);
            chk("reset_resp_err", err[k], 64'd0);
        end
        @(posedge clk); #1;

        // LATENCY=2: store then load
        txn(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, d, e, lat);
        chk("store_latency", 64'(lat), 64'd2);
        chk("store_err", e, 64'd0);
        chk("store_rdata", d, 64'd0);
        txn(0, 1'b0, 64'h10, 64'd0, 0, d, e, lat);
        chk("load_latency", 64'(lat), 64'd2);
        chk("load_rdata", d, 64'hDEADBEEF_CAFEF00D);

        // Backpressure for 5 cycles
        txn(0, 1'b0, 64'h10, 64'd0, 5, d, e, lat);
        chk("bp_rdata", d, 64'hDEADBEEF_CAFEF00D);
        @(negedge clk);
        chk("bp_idle_ready", rdy[0], 64'd1);
        chk("bp_idle_valid", vld[0], 64'd0);
        @(posedge clk); #1;

        // Misaligned store, then the prior data is intact
        txn(0, 1'b1, 64'h13, 64'h0BAD, 0, d, e, lat);
        chk("misaligned_err", e, 64'd1);
        chk("misaligned_rdata", d, 64'd0);
        txn(0, 1'b0, 64'h10, 64'd0, 0, d, e, lat);
        chk("after_misaligned_rdata", d, 64'hDEADBEEF_CAFEF00D);
        chk("after_misaligned_err", e, 64'd0);

        // Out of range
        txn(0, 1'b0, 64'h400, 64'd0, 0, d, e, lat);
        chk("oor_err", e, 64'd1);
        chk("oor_rdata", d, 64'd0);
`ifdef DMEM_STATS_EN
        @(negedge clk);
        chk("stats_ld0", ldc[0], 64'd3);
        chk("stats_st0", stc[0], 64'd1);
        chk("stats_err0", erc[0], 64'd2);
        @(posedge clk); #1;
`endif

        // Reset while the store is in WAIT
        txn(0, 1'b1, 64'h20, 64'h5555AAAA_0F0FF0F0, 0, d, e, lat);
        send(0, 1'b1, 64'h20, 64'h1234, t1);
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", rdy[0], 64'd1);
        chk("midrst_resp_valid", vld[0], 64'd0);
        @(posedge clk); #1;
        txn(0, 1'b0, 64'h20, 64'd0, 0, d, e, lat);
        chk("midrst_load", d, 64'h5555AAAA_0F0FF0F0);

        // LATENCY=1: back-to-back loads
        txn(1, 1'b1, 64'h10, 64'h0123456789ABCDEF, 0, d, e, lat);
        chk("lat1_store_latency", 64'(lat), 64'd1);
        txn(1, 1'b1, 64'h18, 64'hFEDCBA9876543210, 0, d, e, lat);
        send(1, 1'b0, 64'h10, 64'd0, t1);
        @(negedge clk);
        chk("lat1_valid_t1", vld[1], 64'd1);
        chk("lat1_rdata_a", dat[1], 64'h0123456789ABCDEF);
        @(posedge clk); #1;
        send(1, 1'b0, 64'h18, 64'd0, t2);
        chk("lat1_next_accept", 64'(t2 - t1), 64'd2);
        @(negedge clk);
        chk("lat1_valid_t2", vld[1], 64'd1);
        chk("lat1_rdata_b", dat[1], 64'hFEDCBA9876543210);
`ifdef DMEM_STATS_EN
        chk("stats_ld1", ldc[1], 64'd2);
`endif
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the CPU's load/store port (address, write-enable, store data, load data).
- Accepts one request at a time via a valid/ready handshake and returns load data or a store acknowledgement after a fixed latency.
- Backed by a 64-bit-word RAM. Serialised: a new request is accepted only once the previous response has been consumed.
- Sits between the CPU datapath (or a future pipeline stall controller) and on-chip data storage.

Parameters:
- DEPTH, 128, number of 64-bit words; must be a power of two, at least 2.
- LATENCY, 2, cycles from request acceptance to first resp_valid; must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-low reset (0 = reset)
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_wr  input  1  1 = store, 0 = load
- req_addr  input  64  byte address
- req_wdata  input  64  store data
- resp_valid  output  1  response present
- resp_ready  input  1  requester consumes the response
- resp_rdata  output  64  load data; 0 for stores and for errors
- resp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - RAM contents are not cleared.
- States:
  - IDLE: req_ready=1, resp_valid=0. On req_valid, latch req_wr, req_addr and req_wdata (accepted at cycle T). Go to RESP if LATENCY==1, otherwise WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Decrement the counter each cycle; go to RESP on the edge where the counter reaches 1.
  - RESP: resp_valid=1, req_ready=0. Outputs are held stable until resp_ready. On resp_valid && resp_ready go to IDLE and clear resp_valid; resp_rdata and resp_err hold their values.
- Latency: resp_valid first goes high in cycle T+LATENCY. With resp_ready tied high, throughput is one request per LATENCY+1 cycles.
- Address decode:
  - Word index = req_addr[log2(DEPTH)+2 : 3].
  - Error if req_addr[2:0] != 0, or if any bit of req_addr above bit log2(DEPTH)+2 is set.
- RAM access: performed on the edge entering RESP.
  - Load: resp_rdata = mem[index].
  - Store: mem[index] = wdata; resp_rdata = 0.
  - Error case: no RAM write, resp_rdata = 0, resp_err = 1.
- req_ready is never high in the same cycle as resp_valid; there is no pipelining.
- Read-after-write: a load following a store to the same address returns the new data, because requests are serialised.
- Reset mid-operation (in WAIT or RESP): the pending request is abandoned and its store is NOT committed. The first cycle after reset is IDLE.
- req_valid while not ready: ignored. The requester must hold the request until req_ready.

Optional Feature:
- Macro: DMEM_STATS_EN.
- When defined:
  - Adds output ports ld_count [31:0], st_count [31:0] and err_count [31:0].
  - Each counter increments on the edge entering RESP for a load, store or errored request respectively; an errored request increments only err_count.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP) as a 2-bit typedef;
  - WORD_BYTES=8 and WORD_SHIFT=3 constants;
  - the counter width (32).
- Sub-module dmem_array: single-port synchronous RAM with one write-enable and a registered read, DEPTH x 64. The responder FSM, address decode and error logic stay in the top module.

Test Plan:
- Store, then load (LATENCY=2, resp_ready=1):
  - store req_addr=0x10, wdata=0xDEADBEEF_CAFEF00D accepted at T -> resp_valid at T+2, resp_err=0, resp_rdata=0.
  - load 0x10 -> resp_rdata=0xDEADBEEF_CAFEF00D.
- Backpressure: load issued with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata held stable; req_ready=0 throughout; IDLE one cycle after resp_ready=1.
- Misaligned store to 0x13 -> resp_err=1 and resp_rdata=0; a subsequent load of 0x10 still returns the prior data.
- Out-of-range load at 0x400 (DEPTH=128) -> resp_err=1, resp_rdata=0.
- Reset mid-store:
  - store 0x20 = 0x1234 accepted, then rst=0 in WAIT -> resp_valid=0 and req_ready=1 after reset.
  - load 0x20 returns the pre-existing value, not 0x1234.
- LATENCY=1 back-to-back loads with resp_ready=1 -> resp_valid in cycle T+1, next acceptance at T+2; with DMEM_STATS_EN, ld_count=2 after both loads.
